// File: rtl/ps2_key_decoder_pkg.sv
// Shared types for the PS/2 key path feeding camera_controller.
package ps2_key_decoder_pkg;

    // Motion vector used by camera_controller.
    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } vector_t;

    // Per-key strobes: bit0 = press, bit1 = release.
    typedef struct packed {
        logic [1:0] w;
        logic [1:0] a;
        logic [1:0] s;
        logic [1:0] d;
        logic [1:0] q;
        logic [1:0] e;
        logic       pressed;
        logic       released;
    } keys_t;

    // Scan code set 2 values of interest.
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_Q     = 8'h15;
    localparam logic [7:0] SC_E     = 8'h24;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;

    // Key index follows the held bit order {e,q,d,s,a,w}.
    localparam logic [2:0] KEY_W    = 3'd0;
    localparam logic [2:0] KEY_A    = 3'd1;
    localparam logic [2:0] KEY_S    = 3'd2;
    localparam logic [2:0] KEY_D    = 3'd3;
    localparam logic [2:0] KEY_Q    = 3'd4;
    localparam logic [2:0] KEY_E    = 3'd5;
    localparam logic [2:0] KEY_NONE = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

    // Map a scan code to its key index, KEY_NONE when unmapped.
    function automatic logic [2:0] key_index(input logic [7:0] sc);
        logic [2:0] idx;
        case (sc)
            SC_W:    idx = KEY_W;
            SC_A:    idx = KEY_A;
            SC_S:    idx = KEY_S;
            SC_D:    idx = KEY_D;
            SC_Q:    idx = KEY_Q;
            SC_E:    idx = KEY_E;
            default: idx = KEY_NONE;
        endcase
        return idx;
    endfunction

    // Build the one-cycle keys_t strobe for a press (rel=0) or release (rel=1).
    function automatic keys_t key_strobe(input logic [2:0] idx, input logic rel);
        keys_t      k;
        logic [1:0] bits;
        k        = '0;
        bits     = rel ? 2'b10 : 2'b01;
        case (idx)
            KEY_W:   k.w = bits;
            KEY_A:   k.a = bits;
            KEY_S:   k.s = bits;
            KEY_D:   k.d = bits;
            KEY_Q:   k.q = bits;
            KEY_E:   k.e = bits;
            default: k   = '0;
        endcase
        k.pressed  = ~rel;
        k.released = rel;
        return k;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizers, falling-edge detect, 11-bit shifter,
// frame checks and a mid-frame idle timeout.
//
// Output handshake: byte_valid and err are single-cycle strobes with no ready
// path; they are mutually exclusive and the consumer must act on every pulse.
module ps2_rx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       err
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [9:0]             shift_q, shift_d;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [7:0]             byte_q, byte_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   err_q, err_d;

    logic                   sync_clk;
    logic                   sync_data;
    logic                   fall;
    logic                   frame_ok;

    assign sync_clk  = clk_sync_q[SYNC_STAGES-1];
    assign sync_data = data_sync_q[SYNC_STAGES-1];
    assign fall      = clk_prev_q & ~sync_clk;

    // Next-state: shift bits on falling edges, check the frame at the stop bit, abort on idle timeout.
    always_comb begin
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        clk_prev_d   = sync_clk;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        to_cnt_d     = to_cnt_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        err_d        = 1'b0;
        // shift_q holds {parity, data[7:0], start} once ten bits are in.
        frame_ok     = ~shift_q[0] & (^shift_q[9:1]) & sync_data;

        if (fall) begin
            to_cnt_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d    = 4'd0;
                byte_valid_d = frame_ok;
                err_d        = ~frame_ok;
                if (frame_ok) begin
                    byte_d = shift_q[8:1];
                end
            end else begin
                shift_d   = {sync_data, shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                bit_cnt_d = 4'd0;
                to_cnt_d  = '0;
                err_d     = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + TO_W'(1);
            end
        end
    end

    // State register; synchronizers reset to the idle-high line level.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q   <= '1;
            data_sync_q  <= '1;
            clk_prev_q   <= 1'b1;
            bit_cnt_q    <= 4'd0;
            shift_q      <= '0;
            to_cnt_q     <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            clk_prev_q   <= clk_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            to_cnt_q     <= to_cnt_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            err_q        <= err_d;
        end
    end

    assign rx_byte    = byte_q;
    assign byte_valid = byte_valid_q;
    assign err        = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: make/break/extended parsing, typematic suppression,
// held-key tracking and registered one-cycle key event strobes.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output keys_t      keys,
    output logic [5:0] held,
    output logic       rx_err,
    output dec_state_e dbg_state
);

    logic [7:0] rx_byte;
    logic       rx_valid;

    ps2_rx #(
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (rx_valid),
        .err        (rx_err)
    );

    dec_state_e state_q, state_d;
    logic [5:0] held_q, held_d;
    keys_t      keys_q, keys_d;

    logic [2:0] idx;
    logic       mapped;
    logic       make_evt;
    logic       break_evt;

    // Decoder next-state, held update and event strobe, evaluated per received byte.
    always_comb begin
        state_d   = state_q;
        held_d    = held_q;
        keys_d    = '0;
        idx       = key_index(rx_byte);
        mapped    = (idx != KEY_NONE);
        make_evt  = 1'b0;
        break_evt = 1'b0;

        if (rx_err) begin
            state_d = ST_IDLE;
        end else if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte == SC_EXT) begin
                        state_d = ST_EXT;
                    end else if (rx_byte == SC_BREAK) begin
                        state_d = ST_BRK;
                    end else begin
                        make_evt = mapped;
                    end
                end
                ST_BRK: begin
                    break_evt = mapped;
                    state_d   = ST_IDLE;
                end
                ST_EXT: begin
                    // Extended keys are not used; only track the prefix to skip them.
                    state_d = (rx_byte == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                end
                ST_EXT_BRK: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // A repeat of an already-held key, or a release of an idle key, is silent.
        if (make_evt && !held_q[idx]) begin
            held_d[idx] = 1'b1;
            keys_d      = key_strobe(idx, 1'b0);
        end else if (break_evt && held_q[idx]) begin
            held_d[idx] = 1'b0;
            keys_d      = key_strobe(idx, 1'b1);
        end
    end

    // Decoder state, held keys and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            held_q  <= '0;
            keys_q  <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            keys_q  <= keys_d;
        end
    end

    assign keys      = keys_q;
    assign held      = held_q;
    assign dbg_state = state_q;

endmodule
